// File: rtl/decoder_sweep_if.sv
// Handshake bundle for decoder_sweep: control strobes in, registered
// one-hot and sweep status out.
interface decoder_sweep_if #(
  parameter int SEL_W   = 5,
  parameter int DWELL_W = 8
);
  localparam int N = 1 << SEL_W;

  logic               mode;
  logic               en;
  logic               load;
  logic [SEL_W-1:0]   sel_in;
  logic               start;
  logic [DWELL_W-1:0] dwell;
  logic               stop;
  logic [N-1:0]       D;
  logic [SEL_W-1:0]   code;
  logic               busy;
  logic               done;
  logic               wrap;

  modport master (
    output mode, en, load, sel_in, start, dwell, stop,
    input  D, code, busy, done, wrap
  );

  modport slave (
    input  mode, en, load, sel_in, start, dwell, stop,
    output D, code, busy, done, wrap
  );
endinterface

// File: rtl/decoder_sweep.sv
// Registered binary-to-one-hot decoder with direct load and a
// dwell-timed sweep sequencer over every code.
module decoder_sweep #(
  parameter int SEL_W      = 5,
  parameter int DWELL_W    = 8,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  decoder_sweep_if.slave bus
);
  localparam int N = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       d_q, d_d;
  logic [SEL_W-1:0]   code_q, code_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwl_q, dwl_d;
  logic               hold_q, hold_d;
  logic               wrap_q, wrap_d;
  logic               go, ld, adv, last;

  function automatic logic [N-1:0] onehot(
    input logic [SEL_W-1:0] c,
    input logic             e
  );
    onehot = '0;
    if (e) onehot[c] = 1'b1;
  endfunction

  assign go   = bus.mode & bus.start & ~bus.stop;
  assign ld   = ~bus.mode & bus.load;
  assign adv  = bus.en & (cnt_q == '0);
  assign last = (code_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (go) state_d = SWEEP;
      end
      SWEEP: begin
        if (bus.stop)
          state_d = IDLE;
        else if (adv && last && !CONTINUOUS)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // hold_q marks a code latched by load, so en can re-enable it in IDLE
  always_comb begin
    code_d = code_q;
    cnt_d  = cnt_q;
    dwl_d  = dwl_q;
    hold_d = hold_q;
    wrap_d = 1'b0;
    d_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (ld) begin
          code_d = bus.sel_in;
          hold_d = 1'b1;
        end else if (go) begin
          code_d = '0;
          cnt_d  = bus.dwell;
          dwl_d  = bus.dwell;
          hold_d = 1'b0;
        end
        d_d = onehot(code_d, bus.en & (hold_d | go));
      end
      SWEEP: begin
        priority case (1'b1)
          bus.stop:      hold_d = 1'b0;
          !bus.en:       ;
          cnt_q != '0: begin
            cnt_d = cnt_q - 1'b1;
            d_d   = onehot(code_q, 1'b1);
          end
          default: begin
            cnt_d  = dwl_q;
            wrap_d = last & CONTINUOUS;
            if (!(last && !CONTINUOUS)) begin
              code_d = code_q + 1'b1;
              d_d    = onehot(code_d, 1'b1);
            end
          end
        endcase
      end
      DONE:    hold_d = 1'b0;
      default: hold_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q    <= '0;
      code_q <= '0;
      cnt_q  <= '0;
      dwl_q  <= '0;
      hold_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      d_q    <= d_d;
      code_q <= code_d;
      cnt_q  <= cnt_d;
      dwl_q  <= dwl_d;
      hold_q <= hold_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.D    = d_q;
  assign bus.code = code_q;
  assign bus.busy = (state_q == SWEEP);
  assign bus.done = (state_q == DONE);
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_decoder_sweep.sv
// Bench for decoder_sweep: a 5-bit one-shot and a 3-bit continuous
// instance share stimulus and are checked against a sweep model.
module tb_decoder_sweep;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [4:0] sel = '0;
  logic [7:0] dwell = '0;
  bit         chk_on = 1'b0;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  decoder_sweep_if #(.SEL_W(5), .DWELL_W(8)) if5 ();
  decoder_sweep_if #(.SEL_W(3), .DWELL_W(8)) if3 ();

  assign if5.mode   = mode;
  assign if5.en     = en;
  assign if5.load   = load;
  assign if5.sel_in = sel;
  assign if5.start  = start;
  assign if5.dwell  = dwell;
  assign if5.stop   = stop;
  assign if3.mode   = mode;
  assign if3.en     = en;
  assign if3.load   = load;
  assign if3.sel_in = sel[2:0];
  assign if3.start  = start;
  assign if3.dwell  = dwell;
  assign if3.stop   = stop;

  decoder_sweep #(.SEL_W(5), .DWELL_W(8), .CONTINUOUS(1'b0)) u5 (
    .clk(clk), .rst(rst), .bus(if5.slave)
  );
  decoder_sweep #(.SEL_W(3), .DWELL_W(8), .CONTINUOUS(1'b1)) u3 (
    .clk(clk), .rst(rst), .bus(if3.slave)
  );

  // ph: 0 idle, 1 sweeping, 2 finished; spent counts enabled
  // cycles already spent on the current code
  typedef struct {
    int     ph;
    int     code;
    int     spent;
    int     dw;
    bit     held;
    longint d;
    bit     wrap;
  } mdl_t;

  mdl_t m [2];

  task automatic step(inout mdl_t s, input int w, input bit cont);
    int top;
    top = (1 << w) - 1;
    s.wrap = 1'b0;
    if (rst) begin
      s = '{default: 0};
      return;
    end
    case (s.ph)
      0: begin
        if (!mode && load) begin
          s.code = int'(sel) & top;
          s.held = 1'b1;
        end else if (mode && start && !stop) begin
          s.ph = 1; s.code = 0; s.spent = 0;
          s.dw = int'(dwell); s.held = 1'b0;
        end
        s.d = (en && (s.held || s.ph == 1)) ? (longint'(1) << s.code) : 0;
      end
      1: begin
        if (stop) begin
          s.ph = 0; s.d = 0;
        end else if (!en) begin
          s.d = 0;
        end else begin
          s.spent++;
          if (s.spent > s.dw) begin
            s.spent = 0;
            if (s.code == top) begin
              if (cont) begin s.code = 0; s.wrap = 1'b1; end
              else s.ph = 2;
            end else s.code++;
          end
          s.d = (s.ph == 1) ? (longint'(1) << s.code) : 0;
        end
      end
      default: begin
        s.ph = 0; s.d = 0;
      end
    endcase
  endtask

  always @(posedge clk) begin
    step(m[0], 5, 1'b0);
    step(m[1], 3, 1'b1);
  end

  task automatic cmp(input int k, input longint d, input int c,
                     input bit b, input bit dn, input bit wr);
    tests++;
    if (d !== m[k].d || c != m[k].code || b !== (m[k].ph == 1) ||
        dn !== (m[k].ph == 2) || wr !== m[k].wrap) begin
      fails++;
      $display("FAIL model_u%0d t=%0t: D=%h code=%0d busy=%b done=%b wrap=%b required D=%h code=%0d busy=%b done=%b wrap=%b",
        k, $time, d, c, b, dn, wr, m[k].d, m[k].code,
        m[k].ph == 1, m[k].ph == 2, m[k].wrap);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp(0, longint'(if5.D), int'(if5.code), if5.busy, if5.done, if5.wrap);
      cmp(1, longint'(if3.D), int'(if3.code), if3.busy, if3.done, if3.wrap);
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] oh8 [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                          8'h10, 8'h20, 8'h40, 8'h80};

  initial begin
    int nb, done_at, nwrap;
    cyc(2);
    rst = 1'b0;
    chk_on = 1'b1;
    check("rst_D", longint'(if5.D), 0);
    check("rst_code", longint'(if5.code), 0);
    check("rst_busy", longint'(if5.busy), 0);

    // direct mode, 3-bit decode of every code
    mode = 1'b0; en = 1'b1; load = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = 5'(i);
      cyc(1);
      check("dir3_D", longint'(if3.D), longint'(oh8[i]));
      check("dir3_busy", longint'(if3.busy), 0);
    end
    load = 1'b0;

    // direct mode, top code with en toggled
    sel = 5'd31; load = 1'b1;
    cyc(1);
    load = 1'b0;
    check("dir5_D", longint'(if5.D), 64'h8000_0000);
    en = 1'b0;
    cyc(1);
    check("dir5_en0_D", longint'(if5.D), 0);
    check("dir5_en0_code", longint'(if5.code), 31);
    en = 1'b1;
    cyc(1);
    check("dir5_en1_D", longint'(if5.D), 64'h8000_0000);
    check("dir5_en1_code", longint'(if5.code), 31);

    // full one-shot sweep, dwell=2; dwell change mid-sweep ignored
    mode = 1'b1; dwell = 8'd2; start = 1'b1;
    cyc(1);
    start = 1'b0; dwell = 8'd7;
    nb = 0; done_at = -1;
    for (int c = 1; c <= 98; c++) begin
      if (if5.busy) nb++;
      if (if5.done && done_at < 0) begin
        done_at = c;
        check("sw_done_D", longint'(if5.D), 0);
      end
      if (c == 1 || c == 3 || c == 4 || c == 96)
        check("sw_code", longint'(if5.code), (c - 1) / 3);
      if (c == 50) check("sw_D50", longint'(if5.D), 64'h0001_0000);
      if (c == 98) check("sw_idle", longint'({if5.busy, if5.done}), 0);
      cyc(1);
    end
    check("sw_busy_cycles", nb, 96);
    check("sw_done_cycle", done_at, 97);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;

    // continuous 3-bit sweep, dwell=0
    dwell = 8'd0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    nwrap = 0;
    for (int c = 0; c < 20; c++) begin
      check("cont_code", longint'(if3.code), c % 8);
      check("cont_wrap", longint'(if3.wrap), (c == 8 || c == 16) ? 1 : 0);
      check("cont_done", longint'(if3.done), 0);
      if (if3.wrap) nwrap++;
      cyc(1);
    end
    check("cont_wrap_count", nwrap, 2);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;

    // pause at code 4, resume, then stop at code 10
    dwell = 8'd1; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(8);
    check("pause_at4", longint'(if5.code), 4);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("pause_code", longint'(if5.code), 4);
      check("pause_D", longint'(if5.D), 0);
    end
    en = 1'b1;
    cyc(1);
    check("resume_code", longint'(if5.code), 4);
    check("resume_D", longint'(if5.D), 64'h10);
    cyc(1);
    check("resume_next", longint'(if5.code), 5);
    cyc(10);
    check("stop_at10", longint'(if5.code), 10);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check("stop_state", longint'({if5.busy, if5.done}), 0);
    check("stop_D", longint'(if5.D), 0);
    cyc(1);
    check("stop_nodone", longint'(if5.done), 0);

    // reset mid-sweep at code 17
    dwell = 8'd0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(17);
    check("pre_rst_code", longint'(if5.code), 17);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst_mid_D", longint'(if5.D), 0);
    check("rst_mid_code", longint'(if5.code), 0);
    check("rst_mid_flags", longint'({if5.busy, if5.done, if5.wrap}), 0);

    // start together with stop is refused
    start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    check("startstop_busy5", longint'(if5.busy), 0);
    check("startstop_busy3", longint'(if3.busy), 0);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      mode  = 1'($urandom_range(0, 1));
      en    = ($urandom_range(0, 7) != 0);
      load  = ($urandom_range(0, 3) == 0);
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 299) == 0);
      sel   = 5'($urandom);
      dwell = 8'($urandom_range(0, 3));
      cyc(1);
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/decoder_sweep.md
# decoder_sweep

Parametrised binary-to-one-hot decoder with a registered output and a built-in sweep sequencer. It generalises the fixed 3-to-8 and 5-to-32 combinational decoders to SEL_W inputs and 2^SEL_W outputs. It adds two modes: a direct mode, where the output is latched on a load strobe, and a sweep mode, where the block walks every code in order with a programmable dwell time. It sits between control logic and per-line enables, such as bank selects and scan-chain strobes, where a glitch-free registered one-hot is required.

## Interface
- SEL_W, 5, select width; output width is 2^SEL_W (default 5-to-32).
- DWELL_W, 8, width of the dwell count.
- CONTINUOUS, 0, 1 = sweep wraps indefinitely; 0 = sweep ends after the last code.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = direct, 1 = sweep; sampled only in IDLE.
- en  input  1  output enable; low forces D to zero and pauses a sweep.
- load  input  1  direct-mode strobe; latches sel_in.
- sel_in  input  SEL_W  code to decode in direct mode.
- start  input  1  sweep-mode strobe.
- dwell  input  DWELL_W  extra hold cycles per code; sampled at start.
- stop  input  1  abort the sweep.
- D  output  2^SEL_W  registered one-hot output.
- code  output  SEL_W  code currently held.
- busy  output  1  high in SWEEP.
- done  output  1  one-cycle pulse at the end of a sweep.
- wrap  output  1  one-cycle pulse on wrap-around (CONTINUOUS=1 only).

## Operation
- States: IDLE, SWEEP, DONE.
- Reset (rst=1 at an edge) takes priority over everything, including mid-sweep:
  - state = IDLE, D = 0, code = 0.
  - busy, done and wrap = 0.
  - Dwell counter = 0.
- IDLE, mode=0, load=1:
  - code ← sel_in.
  - D ← one-hot(sel_in) if en, else 0.
  - State stays IDLE. D holds until the next load, an en change, or reset.
- IDLE, mode=0, en changes without load: D tracks en against the stored code one cycle later.
- IDLE, mode=1, start=1, stop=0:
  - Go to SWEEP; code ← 0; dwell counter ← dwell.
  - D ← one-hot(0) if en, else 0.
- SWEEP, each cycle with en=1:
  - If the counter is nonzero, decrement it.
  - Otherwise advance code by 1 and reload the counter from the value sampled at start.
- SWEEP, advancing past the all-ones code:
  - CONTINUOUS=0: go to DONE; D ← 0; code holds all-ones.
  - CONTINUOUS=1: code wraps to 0; wrap=1 for exactly that cycle; sweep continues.
- SWEEP, en=0: counter and code freeze; D = 0. The sweep resumes on the same code with the remaining count.
- SWEEP, stop=1: next cycle state = IDLE, D = 0, busy = 0; no done pulse.
- DONE: done=1 for one cycle, then IDLE.
- Ignored inputs:
  - load in mode 1, and start in mode 0.
  - load and start while busy or in DONE.
  - stop in IDLE (also blocks a same-cycle start).
- D is always one-hot or zero; never more than one bit set.

## Timing
- Direct-mode latency: 1 cycle from the load edge to D/code valid.
- Sweep start latency: 1 cycle from the start edge to D = one-hot(0) and busy = 1.
- Each code is held for dwell+1 enabled cycles (dwell=0 gives 1 cycle per code).
- Full sweep with CONTINUOUS=0:
  - Active for 2^SEL_W·(dwell+1) enabled cycles.
  - Then 1 DONE cycle, with busy=0 and done=1.
  - start is accepted again on the following cycle.
- Changing dwell mid-sweep has no effect.
- en is applied to D with 1-cycle latency in all states.
- Stop latency: 1 cycle.

## Test plan
- SEL_W=3, direct mode, en=1: load each sel_in 0..7 for one cycle. Required: D = 8'h01, 02, 04 … 80 one cycle after each load; busy=0 throughout.
- SEL_W=5, direct mode: load sel_in=5'd31 with en=1, then drop en. Required: D = 32'h8000_0000, then 0 one cycle after en falls, then back to 32'h8000_0000 one cycle after en rises, with code=31 throughout.
- SEL_W=5, CONTINUOUS=0, dwell=2: issue start.
  - D walks 1<<0 … 1<<31, each code held 3 cycles; busy=1 for 96 cycles.
  - done=1 on cycle 97 with D=0; IDLE on cycle 98.
- SEL_W=3, CONTINUOUS=1, dwell=0: issue start and run 20 cycles. Required: code sequence 0..7,0..7,0..3; wrap=1 exactly on the two cycles where code returns to 0; done never asserts.
- SEL_W=5, dwell=1: hold en=0 for 5 cycles at code=4, then assert stop at code=10.
  - During the pause: code stays 4 and D=0.
  - On resume: the remaining dwell completes.
  - After stop: IDLE with D=0 and no done pulse.
- Reset mid-sweep at code=17: assert rst for one cycle. Required: next cycle D=0, code=0, busy=done=wrap=0. Also, start and stop asserted together in IDLE leave the block in IDLE.
